// File: rtl/sipo.sv
`default_nettype none
// ============================================================================
//  Module      : sipo
//  Description : Serial-to-parallel frame receiver. Frame format is
//                start(0), DATA_WIDTH data bits LSB-first, parity slot,
//                stop(1). One bit per clock, no oversampling. Recovers the
//                data word and flags parity and framing errors.
//  Ports       : i_clk        - clock, rising edge
//                i_rst        - synchronous active-high reset
//                i_rx         - serial line, idles high
//                i_par_en     - 1: check parity slot, 0: ignore it
//                i_par_type   - 0: even parity, 1: odd parity
//                o_p_data     - last received data word
//                o_data_valid - one-cycle pulse when a frame completes
//                o_par_err    - parity mismatch on last frame
//                o_frame_err  - stop bit sampled low on last frame
//                o_busy       - high while a frame is being received
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx,
    input  logic                  i_par_en,
    input  logic                  i_par_type,
    output logic [DATA_WIDTH-1:0] o_p_data,
    output logic                  o_data_valid,
    output logic                  o_par_err,
    output logic                  o_frame_err,
    output logic                  o_busy
);

    localparam int c_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_DATA      = 3'd1;
    localparam logic [2:0] c_PARITY    = 3'd2;
    localparam logic [2:0] c_STOP      = 3'd3;
    localparam logic [2:0] c_WAIT_HIGH = 3'd4;

    logic [2:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en_l;
    logic                  r_par_type_l;
    logic                  r_par_err_nxt;
    logic                  w_par_exp;

    // Parity bit the transmitter should have sent for the word now in the
    // shift register: even parity -> XOR of data, odd parity -> its inverse.
    assign w_par_exp = (^r_shift) ^ r_par_type_l;

    assign o_busy = (r_state == c_DATA) || (r_state == c_PARITY) || (r_state == c_STOP);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= c_IDLE;
            r_cnt         <= '0;
            r_shift       <= '0;
            r_par_en_l    <= 1'b0;
            r_par_type_l  <= 1'b0;
            r_par_err_nxt <= 1'b0;
            o_p_data      <= '0;
            o_data_valid  <= 1'b0;
            o_par_err     <= 1'b0;
            o_frame_err   <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (!i_rx) begin
                        // Parity settings are frozen for the whole frame.
                        r_state      <= c_DATA;
                        r_cnt        <= '0;
                        r_par_en_l   <= i_par_en;
                        r_par_type_l <= i_par_type;
                    end
                end
                c_DATA: begin
                    // LSB arrives first, so shifting right leaves bit 0 at
                    // position 0 once all DATA_WIDTH bits are in.
                    r_shift <= {i_rx, r_shift[DATA_WIDTH-1:1]};
                    if (r_cnt == c_LAST_BIT) begin
                        r_state <= c_PARITY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_PARITY: begin
                    r_par_err_nxt <= r_par_en_l & (i_rx != w_par_exp);
                    r_state       <= c_STOP;
                end
                c_STOP: begin
                    o_p_data     <= r_shift;
                    o_par_err    <= r_par_err_nxt;
                    o_frame_err  <= ~i_rx;
                    o_data_valid <= 1'b1;
                    // A low stop bit must not be mistaken for the next start
                    // bit; wait for the line to return high first.
                    r_state      <= i_rx ? c_IDLE : c_WAIT_HIGH;
                end
                c_WAIT_HIGH: begin
                    if (i_rx) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sipo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sipo
//  Description : Self-checking bench for sipo. Frames are driven bit by bit;
//                each frame pushes its hand-computed expected result into a
//                queue that a separate monitor pops on every o_data_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo;

    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          par_err;
        logic          frame_err;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          rx;
    logic          par_en;
    logic          par_type;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_err;
    logic          frame_err;
    logic          busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   busy_cnt = 0;
    int   valid_cnt = 0;
    int   exp_valid = 0;
    int   last_valid_cyc = 0;
    int   prev_valid_cyc = 0;
    int   start_cyc = 0;
    logic mon_en = 1'b0;
    exp_t sb_q[$];
    exp_t mon_e;

    sipo #(.DATA_WIDTH(DW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx         (rx),
        .i_par_en     (par_en),
        .i_par_type   (par_type),
        .o_p_data     (p_data),
        .o_data_valid (data_valid),
        .o_par_err    (par_err),
        .o_frame_err  (frame_err),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: outputs are stable on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) busy_cnt++;
            if (data_valid) begin
                valid_cnt++;
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
                if (sb_q.size() == 0) begin
                    check("spurious_valid", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("p_data",    32'(p_data),    32'(mon_e.data));
                    check("par_err",   32'(par_err),   32'(mon_e.par_err));
                    check("frame_err", 32'(frame_err), 32'(mon_e.frame_err));
                end
            end
        end
    end

    // Drive one full frame starting on a falling edge; optionally flip
    // par_en just before bit index toggle_at.
    task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic sbit,
                              input logic exp_pe, input logic exp_fe, input int toggle_at);
        logic [DW+2:0] fr;
        exp_t e;
        fr = {sbit, pbit, d, 1'b0};
        e.data = d;
        e.par_err = exp_pe;
        e.frame_err = exp_fe;
        sb_q.push_back(e);
        exp_valid++;
        for (int i = 0; i < DW + 3; i++) begin
            if (i == toggle_at) par_en = ~par_en;
            rx = fr[i];
            if (i == 0) start_cyc = cyc + 1;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW+2:0] fr5;
        rst = 1'b1;
        rx = 1'b1;
        par_en = 1'b0;
        par_type = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Reset state
        check("rst_p_data",    32'(p_data),     32'h0);
        check("rst_valid",     32'(data_valid), 32'h0);
        check("rst_par_err",   32'(par_err),    32'h0);
        check("rst_frame_err", 32'(frame_err),  32'h0);
        check("rst_busy",      32'(busy),       32'h0);
        idle(2);

        // 1: parity disabled, 0xA5
        busy_cnt = 0;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        idle(3);
        check("t1_busy_cycles", 32'(busy_cnt), 32'd10);
        check("t1_latency", 32'(last_valid_cyc - start_cyc), 32'(DW + 2));
        check("t1_valid_cycles", 32'(valid_cnt), 32'(exp_valid));

        // 2: even parity, good then bad parity bit
        par_en = 1'b1;
        par_type = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        idle(2);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        idle(2);

        // 3: odd parity, good parity, bad stop bit, line held low
        par_type = 1'b1;
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        rx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t3_busy_wait_high", 32'(busy), 32'h0);
            @(negedge clk);
        end
        check("t3_no_spurious", 32'(valid_cnt), 32'(exp_valid));
        idle(1);
        send_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        idle(2);

        // 4: back-to-back frames, no idle gap
        par_en = 1'b0;
        send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        idle(2);
        check("t4_pulse_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'd11);
        check("t4_valid_cycles", 32'(valid_cnt), 32'(exp_valid));

        // 5: reset during data bit 4 of 0x5A
        fr5 = {1'b1, 1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx = fr5[i];
            @(negedge clk);
        end
        rx = fr5[5];
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx = 1'b1;
        check("t5_p_data",    32'(p_data),    32'h0);
        check("t5_par_err",   32'(par_err),   32'h0);
        check("t5_frame_err", 32'(frame_err), 32'h0);
        check("t5_busy",      32'(busy),      32'h0);
        idle(12);
        check("t5_no_valid", 32'(valid_cnt), 32'(exp_valid));
        send_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        idle(2);

        // 6: par_en dropped mid-frame; bad parity still flagged
        par_en = 1'b1;
        par_type = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 5);
        idle(3);

        check("final_valid_cycles", 32'(valid_cnt), 32'(exp_valid));
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
